// File: rtl/stream_mux_arb.sv
// N:1 valid/ready stream mux with fixed-priority or round-robin arbitration
// and a single registered output stage that holds its word until the sink accepts it.
module stream_mux_arb #(
  parameter int WIDTH   = 32,
  parameter int N       = 8,
  parameter int RR_MODE = 1,
  localparam int SELW   = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [N-1:0]       valid_i,
  output logic [N-1:0]       ready_o,
  output logic [WIDTH-1:0]   data_o,
  output logic               valid_o,
  output logic [SELW-1:0]    sel_o,
  input  logic               ready_i
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] grant_data;
  logic             any_req;
  logic             load;

  assign any_req = |valid_i;
  // Output register is empty or being drained this cycle.
  assign load    = !valid_o || ready_i;

  // Scan from the pointer (or from 0 in fixed priority), wrapping at N.
  always_comb begin : arb
    int   start;
    int   idx;
    logic found;
    start = (RR_MODE != 0) ? int'(ptr) : 0;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = start + i;
      if (idx >= N) idx = idx - N;
      if (!found && valid_i[idx]) begin
        found = 1'b1;
        grant = idx[SELW-1:0];
      end
    end
  end

  assign grant_data = data_i[int'(grant)*WIDTH +: WIDTH];
  assign ptr_next   = (int'(grant) == N - 1) ? '0 : SELW'(int'(grant) + 1);

  always_comb begin
    ready_o = '0;
    if (load && any_req && !rst_i) ready_o[grant] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      sel_o   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (any_req) begin
        data_o  <= grant_data;
        sel_o   <= grant;
        valid_o <= 1'b1;
        if (RR_MODE != 0) ptr <= ptr_next;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: three instances (fixed N=8, RR N=8, RR N=5) sharing stimulus,
// checked against directed constants and a queue-free behavioural model of the arbitration rules.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          rdy;
  logic [7:0]    vin;
  logic [31:0]   din [8];
  logic [255:0]  dbus;

  for (genvar k = 0; k < 8; k++) begin : g_pack
    assign dbus[k*32 +: 32] = din[k];
  end

  logic [7:0]  r0, r1;
  logic [4:0]  r2;
  logic [31:0] q0, q1, q2;
  logic        v0, v1, v2;
  logic [2:0]  s0, s1, s2;

  stream_mux_arb #(.WIDTH(32), .N(8), .RR_MODE(0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .data_i(dbus), .valid_i(vin),
    .ready_o(r0), .data_o(q0), .valid_o(v0), .sel_o(s0), .ready_i(rdy));

  stream_mux_arb #(.WIDTH(32), .N(8), .RR_MODE(1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .data_i(dbus), .valid_i(vin),
    .ready_o(r1), .data_o(q1), .valid_o(v1), .sel_o(s1), .ready_i(rdy));

  stream_mux_arb #(.WIDTH(32), .N(5), .RR_MODE(1)) dut_n5 (
    .clk_i(clk), .rst_i(rst), .data_i(dbus[159:0]), .valid_i(vin[4:0]),
    .ready_o(r2), .data_o(q2), .valid_o(v2), .sel_o(s2), .ready_i(rdy));

  int checks = 0;
  int errors = 0;

  // Reference model state, one entry per instance.
  int          nn [3] = '{8, 8, 5};
  bit          rr [3] = '{1'b0, 1'b1, 1'b1};
  logic        m_v [3];
  logic [31:0] m_d [3];
  int          m_s [3];
  int          m_p [3];
  logic [7:0]  exp_r [3];
  logic [7:0]  act_r [3];
  logic        act_v [3];
  logic [31:0] act_d [3];
  int          act_s [3];

  function automatic int pick(input logic [7:0] v, input int p, input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      int k;
      k = r ? (p + i) % n : i;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Advance one clock: record pre-edge ready_o and model expectation, then
  // update the model with the inputs seen at the edge and sample registered outputs.
  task automatic step();
    int   g [3];
    logic ld [3];
    logic [7:0] vv;
    #1;
    act_r[0] = r0; act_r[1] = r1; act_r[2] = {3'b000, r2};
    for (int d = 0; d < 3; d++) begin
      vv = (d == 2) ? (vin & 8'h1F) : vin;
      g[d]  = pick(vv, m_p[d], nn[d], rr[d]);
      ld[d] = !m_v[d] || rdy;
      exp_r[d] = (!rst && ld[d] && g[d] >= 0) ? 8'(1 << g[d]) : 8'h00;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_v[d] = 1'b0; m_d[d] = '0; m_s[d] = 0; m_p[d] = 0;
      end else if (ld[d]) begin
        if (g[d] >= 0) begin
          m_v[d] = 1'b1; m_d[d] = din[g[d]]; m_s[d] = g[d];
          if (rr[d]) m_p[d] = (g[d] == nn[d] - 1) ? 0 : g[d] + 1;
        end else begin
          m_v[d] = 1'b0;
        end
      end
    end
    #1;
    act_v[0] = v0; act_v[1] = v1; act_v[2] = v2;
    act_d[0] = q0; act_d[1] = q1; act_d[2] = q2;
    act_s[0] = int'(s0); act_s[1] = int'(s1); act_s[2] = int'(s2);
  endtask

  task automatic set_data_idx();
    for (int k = 0; k < 8; k++) din[k] = 32'hA000_0000 | k;
  endtask

  task automatic do_reset();
    rst = 1'b1; vin = 8'h00; rdy = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vin = 8'hFF; rdy = 1'b1;
    set_data_idx();
    for (int c = 0; c < 3; c++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_r[d] !== 8'h00) begin errors++; $display("FAIL reset_ready dut%0d act=%0h exp=0", d, act_r[d]); end
        checks++;
        if (act_v[d] !== 1'b0 || act_d[d] !== 32'h0 || act_s[d] !== 0) begin
          errors++; $display("FAIL reset_regs dut%0d act v=%0b d=%0h s=%0d exp 0/0/0", d, act_v[d], act_d[d], act_s[d]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    set_data_idx();
    vin = 8'b1010_0100; rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (act_r[0] !== 8'h04) begin errors++; $display("FAIL fp_ready act=%0h exp=04", act_r[0]); end
      checks++;
      if (act_v[0] !== 1'b1 || act_s[0] !== 2 || act_d[0] !== 32'hA000_0002) begin
        errors++; $display("FAIL fp_out act v=%0b s=%0d d=%0h exp 1/2/a0000002", act_v[0], act_s[0], act_d[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_data_idx();
    vin = 8'hFF; rdy = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      checks++;
      if (act_v[1] !== 1'b1 || act_s[1] !== c % 8 || act_d[1] !== (32'hA000_0000 | (c % 8))) begin
        errors++; $display("FAIL rr_seq cyc%0d act v=%0b s=%0d exp 1/%0d", c, act_v[1], act_s[1], c % 8);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data_idx();
    vin = 8'b0000_1000; rdy = 1'b1;
    step();
    checks++;
    if (act_s[1] !== 3 || act_v[1] !== 1'b1) begin errors++; $display("FAIL bp_latch act s=%0d v=%0b exp 3/1", act_s[1], act_v[1]); end
    vin = 8'hFF; rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (act_r[1] !== 8'h00) begin errors++; $display("FAIL bp_ready act=%0h exp=0", act_r[1]); end
      checks++;
      if (act_s[1] !== 3 || act_d[1] !== 32'hA000_0003 || act_v[1] !== 1'b1) begin
        errors++; $display("FAIL bp_hold act s=%0d d=%0h exp 3/a0000003", act_s[1], act_d[1]);
      end
    end
    rdy = 1'b1;
    step();
    checks++;
    if (act_r[1] !== 8'h10) begin errors++; $display("FAIL bp_release_ready act=%0h exp=10", act_r[1]); end
    checks++;
    if (act_s[1] !== 4) begin errors++; $display("FAIL bp_release_sel act=%0d exp=4", act_s[1]); end
  endtask

  task automatic test_drain_idle();
    do_reset();
    set_data_idx();
    vin = 8'b0010_0000; rdy = 1'b1;
    step();
    checks++;
    if (act_v[1] !== 1'b1 || act_s[1] !== 5) begin errors++; $display("FAIL drain_load act v=%0b s=%0d exp 1/5", act_v[1], act_s[1]); end
    vin = 8'h00;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (act_v[1] !== 1'b0 || act_s[1] !== 5 || act_d[1] !== 32'hA000_0005) begin
        errors++; $display("FAIL drain_idle act v=%0b s=%0d d=%0h exp 0/5/a0000005", act_v[1], act_s[1], act_d[1]);
      end
    end
    vin = 8'b0100_0001;
    step();
    checks++;
    if (act_s[1] !== 6 || act_v[1] !== 1'b1) begin errors++; $display("FAIL drain_ptr act s=%0d exp=6", act_s[1]); end
  endtask

  task automatic test_n5();
    int exp_seq [4] = '{4, 0, 4, 0};
    do_reset();
    set_data_idx();
    vin = 8'b0000_1000; rdy = 1'b1;
    step();
    vin = 8'b0001_0001;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (act_s[2] !== exp_seq[c] || act_v[2] !== 1'b1) begin
        errors++; $display("FAIL n5_alt cyc%0d act=%0d exp=%0d", c, act_s[2], exp_seq[c]);
      end
    end
    rst = 1'b1;
    step();
    checks++;
    if (act_v[2] !== 1'b0) begin errors++; $display("FAIL n5_rst_valid act=%0b exp=0", act_v[2]); end
    rst = 1'b0;
    step();
    checks++;
    if (act_s[2] !== 0 || act_v[2] !== 1'b1) begin errors++; $display("FAIL n5_after_rst act s=%0d v=%0b exp 0/1", act_s[2], act_v[2]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 8; k++) din[k] = $urandom;
      vin = 8'($urandom);
      if ($urandom_range(0, 5) == 0) vin = 8'h00;
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      step();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_r[d] !== exp_r[d]) begin errors++; $display("FAIL rand_ready dut%0d cyc%0d act=%0h exp=%0h", d, c, act_r[d], exp_r[d]); end
        checks++;
        if (act_v[d] !== m_v[d] || act_d[d] !== m_d[d] || act_s[d] !== m_s[d]) begin
          errors++; $display("FAIL rand_out dut%0d cyc%0d act v=%0b d=%0h s=%0d exp v=%0b d=%0h s=%0d",
                             d, c, act_v[d], act_d[d], act_s[d], m_v[d], m_d[d], m_s[d]);
        end
        if (act_s[d] >= nn[d]) begin
          errors++; $display("FAIL rand_sel_range dut%0d act=%0d exp<%0d", d, act_s[d], nn[d]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_v[d] = 1'b0; m_d[d] = '0; m_s[d] = 0; m_p[d] = 0;
    end
    rst = 1'b1; rdy = 1'b1; vin = 8'h00;
    for (int k = 0; k < 8; k++) din[k] = '0;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_backpressure();
    test_drain_idle();
    test_n5();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
